// File: rtl/alu_24bit.sv
// ============================================================================
//  Module      : alu_24bit
//  Description : MIPS-style ALU built from ripple-carry 1-bit cells, with
//                AND/OR/ADD/LESS select and a registered result and carry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_24bit #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             binv,
    input  logic [WIDTH-1:0] less,
    input  logic             sel1,
    input  logic             sel0,
    output logic [WIDTH-1:0] result,
    output logic             co
);

    localparam logic [1:0] c_op_and  = 2'b00;
    localparam logic [1:0] c_op_or   = 2'b01;
    localparam logic [1:0] c_op_add  = 2'b10;
    localparam logic [1:0] c_op_less = 2'b11;

    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_carry;
    logic [1:0]       w_sel;
    logic [WIDTH-1:0] r_result;
    logic             r_co;

    assign w_sel      = {sel1, sel0};
    assign w_carry[0] = cin;

    // One slice per bit; the carry chain ripples through every slice
    // regardless of the selected operation.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic w_bb;
        logic w_sum;

        assign w_bb           = b[i] ^ binv;
        assign w_sum          = a[i] ^ w_bb ^ w_carry[i];
        assign w_carry[i + 1] = (a[i] & w_bb) | (a[i] & w_carry[i]) | (w_bb & w_carry[i]);

        always_comb begin
            w_res[i] = 1'b0;
            case (w_sel)
                c_op_and:  w_res[i] = a[i] & w_bb;
                c_op_or:   w_res[i] = a[i] | w_bb;
                c_op_add:  w_res[i] = w_sum;
                c_op_less: w_res[i] = less[i];
                default:   w_res[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
            r_co     <= 1'b0;
        end else begin
            r_result <= w_res;
            r_co     <= w_carry[WIDTH];
        end
    end

    assign result = r_result;
    assign co     = r_co;

endmodule

`default_nettype wire

// File: tb/tb_alu_24bit.sv
// ============================================================================
//  Module      : tb_alu_24bit
//  Description : Self-checking bench for alu_24bit: directed cases plus
//                randomized steps against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_24bit;

    logic        clk;
    logic        rst_n;
    logic [23:0] a;
    logic [23:0] b;
    logic        cin;
    logic        binv;
    logic [23:0] less;
    logic        sel1;
    logic        sel0;
    logic [23:0] result;
    logic        co;

    int n_cmp;
    int n_err;

    alu_24bit #(.WIDTH(24)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .binv   (binv),
        .less   (less),
        .sel1   (sel1),
        .sel0   (sel0),
        .result (result),
        .co     (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {co, result} from plain integer arithmetic.
    function automatic logic [24:0] model(input logic [23:0] ma, input logic [23:0] mb,
                                          input logic mcin, input logic mbinv,
                                          input logic [23:0] mless, input logic [1:0] msel);
        logic [23:0] bb;
        logic [24:0] full;
        logic [23:0] r;
        bb   = mbinv ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {24'd0, mcin};
        case (msel)
            2'b00:   r = ma & bb;
            2'b01:   r = ma | bb;
            2'b10:   r = full[23:0];
            default: r = mless;
        endcase
        return {full[24], r};
    endfunction

    // Apply one set of inputs, clock once, and check the registered outputs.
    task automatic step(input string tag, input logic rn, input logic [23:0] ta,
                        input logic [23:0] tb, input logic tcin, input logic tbinv,
                        input logic [23:0] tless, input logic [1:0] tsel);
        logic [24:0] exp;
        logic [24:0] obs;
        rst_n = rn;
        a     = ta;
        b     = tb;
        cin   = tcin;
        binv  = tbinv;
        less  = tless;
        {sel1, sel0} = tsel;
        exp = rn ? model(ta, tb, tcin, tbinv, tless, tsel) : 25'd0;
        @(posedge clk);
        #1;
        obs = {co, result};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed co=%b result=%h, expected co=%b result=%h",
                   tag, obs[24], obs[23:0], exp[24], exp[23:0]);
        end
    endtask

    initial begin
        logic [23:0] ra, rb, rl;
        logic        rc, rbi, rrn;
        logic [1:0]  rs;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0; binv = 1'b0; less = '0; sel1 = 1'b0; sel0 = 1'b0;
        @(negedge clk);

        // Reset, then release with a carry-producing add.
        step("rst0",      1'b0, 24'hffffff, 24'hffffff, 1'b0, 1'b0, 24'h0, 2'b10);
        step("rst1",      1'b0, 24'hffffff, 24'hffffff, 1'b0, 1'b0, 24'h0, 2'b10);
        step("rst_rel",   1'b1, 24'hffffff, 24'hffffff, 1'b0, 1'b0, 24'h0, 2'b10);

        // ADD
        step("add_alt",   1'b1, 24'haaaaaa, 24'h555555, 1'b0, 1'b0, 24'h0, 2'b10);
        step("add_wrap",  1'b1, 24'haaaaaa, 24'h555555, 1'b1, 1'b0, 24'h0, 2'b10);
        step("add_123",   1'b1, 24'h123456, 24'h654321, 1'b0, 1'b0, 24'h0, 2'b10);
        step("add_123c",  1'b1, 24'h123456, 24'h654321, 1'b1, 1'b0, 24'h0, 2'b10);

        // Logic
        step("and_alt",   1'b1, 24'haaaaaa, 24'h555555, 1'b0, 1'b0, 24'h0, 2'b00);
        step("or_alt",    1'b1, 24'haaaaaa, 24'h555555, 1'b0, 1'b0, 24'h0, 2'b01);
        step("and_123",   1'b1, 24'h123456, 24'h654321, 1'b0, 1'b0, 24'h0, 2'b00);
        step("or_123",    1'b1, 24'h123456, 24'h654321, 1'b0, 1'b0, 24'h0, 2'b01);
        step("and_binv",  1'b1, 24'haaaaaa, 24'h555555, 1'b0, 1'b1, 24'h0, 2'b00);

        // SUB
        step("sub_pos",   1'b1, 24'h654321, 24'h123456, 1'b1, 1'b1, 24'h0, 2'b10);
        step("sub_neg",   1'b1, 24'h123456, 24'h654321, 1'b1, 1'b1, 24'h0, 2'b10);
        step("sub_eq",    1'b1, 24'h555555, 24'h555555, 1'b1, 1'b1, 24'h0, 2'b10);

        // LESS
        step("less_1",    1'b1, 24'h123456, 24'h654321, 1'b0, 1'b0, 24'h000001, 2'b11);
        step("less_0",    1'b1, 24'h123456, 24'h654321, 1'b0, 1'b0, 24'h000000, 2'b11);
        step("less_co",   1'b1, 24'hffffff, 24'h000001, 1'b0, 1'b0, 24'h5a5a5a, 2'b11);

        // Back-to-back across modes with a mid-stream reset.
        step("b2b_and",   1'b1, 24'hf0f0f0, 24'h0ff0ff, 1'b0, 1'b0, 24'h0, 2'b00);
        step("b2b_or",    1'b1, 24'hf0f0f0, 24'h0ff0ff, 1'b0, 1'b0, 24'h0, 2'b01);
        step("b2b_rst",   1'b0, 24'hffffff, 24'h000001, 1'b0, 1'b0, 24'h0, 2'b10);
        step("b2b_add",   1'b1, 24'hffffff, 24'h000001, 1'b0, 1'b0, 24'h0, 2'b10);
        step("b2b_less",  1'b1, 24'h000000, 24'h000000, 1'b0, 1'b1, 24'h800000, 2'b11);

        // Randomized steps, occasionally with reset asserted.
        for (int i = 0; i < 300; i++) begin
            ra  = 24'($urandom);
            rb  = 24'($urandom);
            rl  = 24'($urandom);
            rc  = 1'($urandom);
            rbi = 1'($urandom);
            rs  = 2'($urandom);
            rrn = ($urandom_range(0, 19) != 0);
            step("rand", rrn, ra, rb, rc, rbi, rl, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_24bit.md
Name: alu_24bit

Overview:
24-bit MIPS-style ALU slice array built as ripple-carry 1-bit cells. It supports AND, OR, ADD/SUB (via b-invert and carry-in) and a pass-through "less" operation for set-less-than. Operands are combinational inputs; result and carry-out are registered once per clock. It sits in the MIPS_Archi datapath execute stage, with ALU control decoding into binv, cin, sel1 and sel0.

Parameters:
WIDTH, 24, datapath width; all bit-level rules below scale with it.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
a  input  24  operand A
b  input  24  operand B
cin  input  1  carry into bit 0
binv  input  1  1 = use ~b in the adder and logic cells, 0 = use b
less  input  24  per-bit "less" inputs, selected in SLT mode (normally only bit 0 driven, from external sign logic)
sel1  input  1  operation select MSB
sel0  input  1  operation select LSB
result  output  24  registered operation result
co  output  1  registered carry out of bit 23 of the adder

Behaviour:
- Effective operand: bb = binv ? ~b : b (bitwise, all 24 bits).
- Adder: {c24, sum} = a + bb + cin, as a full 24-bit ripple. Carry into bit i+1 is the carry out of bit i, and c24 is the carry out of bit 23.
- Operation select {sel1,sel0}:
  - 00: AND, a & bb
  - 01: OR, a | bb
  - 10: ADD, sum
  - 11: LESS, result = less (bitwise pass-through)
- co = c24 in every mode. The adder is always active, independent of sel.
- Subtraction: binv=1, cin=1 gives a − b (two's complement). co=1 means no borrow (a ≥ b unsigned).
- Overflow and zero flags are not provided. The SLT sign bit is computed outside the block and fed back on less[0].
- Timing: combinational inputs are sampled on the clk rising edge, so result/co are valid 1 cycle after the inputs. New inputs are accepted every cycle, with no handshake.
- Reset: when rst_n=0 at a rising edge, result <= 24'h000000 and co <= 0. Reset has priority over the operation. Reset asserted mid-stream discards the in-flight computation. The first valid result appears on the edge after the first edge with rst_n=1.
- Before the first reset, output values are undefined; the bench must reset first.
- Wrap-around: the sum is modulo 2^24, and the excess is reported only on co.
- X/Z on an unused operand still propagates into co, because the adder is always evaluated.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with a=ffffff, b=ffffff, sel=10 -> result=000000, co=0. Release rst_n -> next cycle result=fffffe, co=1.
2. ADD: a=aaaaaa, b=555555, cin=0, sel=10 -> result=ffffff, co=0. Same with cin=1 -> result=000000, co=1. a=123456, b=654321, cin=0 -> 777777, co=0; cin=1 -> 777778, co=0.
3. Logic: a=aaaaaa, b=555555, sel=00 -> 000000; sel=01 -> ffffff. a=123456, b=654321, sel=00 -> 000000; sel=01 -> 777777. With binv=1, a=aaaaaa, b=555555, sel=00 -> aaaaaa.
4. SUB: a=654321, b=123456, binv=1, cin=1, sel=10 -> 530ecb, co=1. Swapped operands -> acf135, co=0. a=b=555555 -> 000000, co=1.
5. LESS: sel=11, less=000001, a=123456, b=654321 -> result=000001, with co equal to the adder carry for those operands (0 with binv=0, cin=0). less=000000 -> 000000.
6. Back-to-back: change inputs every cycle across all four modes -> each result appears exactly one cycle after its inputs. Assert rst_n=0 mid-sequence -> result/co=0 on that edge.
